// File: rtl/abuf2ddr.sv
// abuf2ddr: moves conf_trans_num+1 entries from one accumulation-buffer bank onto
// the DDR write stream as DDR_W-bit beats (data and/or tail) through a 2-entry holding buffer.
module abuf2ddr #(
    parameter int unsigned BUF_DEPTH = 512,
    parameter int unsigned ADDR_W    = $clog2(BUF_DEPTH),
    parameter int unsigned DDR_W     = 512,
    parameter int unsigned BATCH     = 32,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TAIL_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    input  logic [1:0]              conf_trans_type,
    input  logic [7:0]              conf_trans_num,
    input  logic [ADDR_W-1:0]       conf_base_addr,
    output logic                    abuf_rd_en,
    output logic [ADDR_W-1:0]       abuf_rd_addr,
    input  logic [BATCH*DATA_W-1:0] abuf_rd_data,
    input  logic [BATCH*TAIL_W-1:0] abuf_rd_tail,
    output logic [DDR_W-1:0]        ddr_data,
    output logic                    ddr_valid,
    output logic                    ddr_last,
    input  logic                    ddr_ready
);
    localparam int unsigned DW      = BATCH * DATA_W;
    localparam int unsigned TW      = BATCH * TAIL_W;
    localparam int unsigned TD_RATE = TW / DDR_W;
    localparam int unsigned BEAT_W  = $clog2(TD_RATE + 2);
    localparam int unsigned CNT_W   = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          type_q, type_d;
    logic [7:0]          num_q, num_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [CNT_W-1:0]    popped_q, popped_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [1:0]          held_q, held_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic                rd_vld_q, rd_vld_d;
    logic [DW-1:0]       hb_data_q [2];
    logic [DW-1:0]       hb_data_d [2];
    logic [TW-1:0]       hb_tail_q [2];
    logic [TW-1:0]       hb_tail_d [2];
    logic                ddr_valid_q, ddr_valid_d;
    logic                ddr_last_q, ddr_last_d;
    logic [DDR_W-1:0]    ddr_data_q, ddr_data_d;
    logic                done_q, done_d;

    logic                fire, final_beat, pop, rd_en_c;
    logic [BEAT_W-1:0]   last_beat_idx, tail_idx;
    logic [DW-1:0]       head_data;
    logic [TW-1:0]       head_tail;

    // Beat index of the last beat of an entry for the latched transfer type
    always_comb begin
        case (type_q)
            2'd0:    last_beat_idx = '0;
            2'd1:    last_beat_idx = BEAT_W'(TD_RATE - 1);
            default: last_beat_idx = BEAT_W'(TD_RATE);
        endcase
    end

    assign fire       = ddr_valid_q && ddr_ready;
    assign final_beat = (beat_q == last_beat_idx);
    assign pop        = fire && final_beat;
    // Read only when the returning entry is guaranteed a holding slot; this cycle's pop counts
    assign rd_en_c    = (state_q == S_RUN) && !rst && (issued_q <= {1'b0, num_q}) &&
                        ((3'(held_q) + 3'(rd_vld_q)) < (3'd2 + 3'(pop)));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (conf_trans_type == 2'd3) ? S_DONE : S_RUN;
            S_RUN:   if (fire && ddr_last_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        type_d      = type_q;
        num_d       = num_q;
        addr_d      = addr_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        beat_d      = beat_q;
        held_d      = held_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_vld_d    = rd_en_c;
        hb_data_d   = hb_data_q;
        hb_tail_d   = hb_tail_q;
        tail_idx    = '0;
        head_data   = '0;
        head_tail   = '0;
        ddr_valid_d = 1'b0;
        ddr_last_d  = 1'b0;
        ddr_data_d  = ddr_data_q;
        done_d      = (state_d == S_DONE);

        if (state_q == S_IDLE) begin
            if (start) begin
                type_d   = conf_trans_type;
                num_d    = conf_trans_num;
                addr_d   = conf_base_addr;
                issued_d = '0;
                popped_d = '0;
                beat_d   = '0;
                held_d   = '0;
                wr_ptr_d = 1'b0;
                rd_ptr_d = 1'b0;
            end
        end else begin
            if (rd_en_c) begin
                addr_d   = (addr_q == ADDR_W'(BUF_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                issued_d = issued_q + CNT_W'(1);
            end
            if (rd_vld_q) begin
                hb_data_d[wr_ptr_q] = abuf_rd_data;
                hb_tail_d[wr_ptr_q] = abuf_rd_tail;
                wr_ptr_d            = !wr_ptr_q;
            end
            if (fire) beat_d = final_beat ? '0 : beat_q + BEAT_W'(1);
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
                popped_d = popped_q + CNT_W'(1);
            end
            held_d = held_q + 2'(rd_vld_q) - 2'(pop);
        end

        // Present the current beat of the head entry; an entry arriving this cycle bypasses in
        if (state_d == S_RUN && held_d != 2'd0) begin
            head_data   = hb_data_d[rd_ptr_d];
            head_tail   = hb_tail_d[rd_ptr_d];
            tail_idx    = (type_q == 2'd2) ? beat_d - BEAT_W'(1) : beat_d;
            ddr_valid_d = 1'b1;
            if (type_q == 2'd0 || (type_q == 2'd2 && beat_d == '0)) begin
                ddr_data_d = DDR_W'(head_data);
            end else begin
                for (int unsigned k = 0; k < TD_RATE; k++) begin
                    if (tail_idx == BEAT_W'(k)) ddr_data_d = head_tail[k*DDR_W +: DDR_W];
                end
            end
            ddr_last_d = (popped_d == {1'b0, num_q}) && (beat_d == last_beat_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q      <= '0;
            num_q       <= '0;
            addr_q      <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            beat_q      <= '0;
            held_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            ddr_valid_q <= 1'b0;
            ddr_last_q  <= 1'b0;
            ddr_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            type_q      <= type_d;
            num_q       <= num_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            beat_q      <= beat_d;
            held_q      <= held_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_vld_q    <= rd_vld_d;
            ddr_valid_q <= ddr_valid_d;
            ddr_last_q  <= ddr_last_d;
            ddr_data_q  <= ddr_data_d;
            done_q      <= done_d;
        end
    end

    // Payload storage; occupancy is tracked by held_q so no reset is needed
    always_ff @(posedge clk) begin
        hb_data_q <= hb_data_d;
        hb_tail_q <= hb_tail_d;
    end

    assign abuf_rd_en   = rd_en_c;
    assign abuf_rd_addr = addr_q;
    assign ddr_data     = ddr_data_q;
    assign ddr_valid    = ddr_valid_q;
    assign ddr_last     = ddr_last_q;
    assign done         = done_q;

endmodule

// File: tb/tb_abuf2ddr.sv
// tb_abuf2ddr: directed and randomized transfers for abuf2ddr, checked against a
// beat-list model built from the buffer contents and the transfer config.
module tb_abuf2ddr;
    localparam int unsigned BUF_DEPTH = 512;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned DDR_W     = 512;
    localparam int unsigned BATCH     = 32;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned TAIL_W    = 32;
    localparam int unsigned DW        = BATCH * DATA_W;
    localparam int unsigned TW        = BATCH * TAIL_W;
    localparam int unsigned TD_RATE   = TW / DDR_W;

    typedef struct {
        logic [DDR_W-1:0] data;
        logic             last;
        logic             ent_end;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              done;
    logic [1:0]        conf_trans_type;
    logic [7:0]        conf_trans_num;
    logic [ADDR_W-1:0] conf_base_addr;
    logic              abuf_rd_en;
    logic [ADDR_W-1:0] abuf_rd_addr;
    logic [DW-1:0]     abuf_rd_data;
    logic [TW-1:0]     abuf_rd_tail;
    logic [DDR_W-1:0]  ddr_data;
    logic              ddr_valid;
    logic              ddr_last;
    logic              ddr_ready;

    logic [DW-1:0]     mem_d [BUF_DEPTH];
    logic [TW-1:0]     mem_t [BUF_DEPTH];

    beat_t             exp_q[$];
    int unsigned       exp_addr[$];
    int                tests = 0;
    int                fails = 0;
    int                cyc_n = 0;
    int                t0, beat_i, rd_i, accepted, done_cnt, done_cyc;
    bit                timed_beats, timed_reads;
    logic              stall_prev;
    logic [DDR_W-1:0]  prev_data;
    logic              prev_last;

    always #5 clk = ~clk;

    abuf2ddr #(
        .BUF_DEPTH(BUF_DEPTH), .ADDR_W(ADDR_W), .DDR_W(DDR_W),
        .BATCH(BATCH), .DATA_W(DATA_W), .TAIL_W(TAIL_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .conf_trans_type(conf_trans_type), .conf_trans_num(conf_trans_num),
        .conf_base_addr(conf_base_addr), .abuf_rd_en(abuf_rd_en),
        .abuf_rd_addr(abuf_rd_addr), .abuf_rd_data(abuf_rd_data),
        .abuf_rd_tail(abuf_rd_tail), .ddr_data(ddr_data), .ddr_valid(ddr_valid),
        .ddr_last(ddr_last), .ddr_ready(ddr_ready)
    );

    // Buffer bank: data valid one cycle after the read strobe, scrambled otherwise
    always @(posedge clk) begin
        if (abuf_rd_en) begin
            abuf_rd_data <= mem_d[abuf_rd_addr];
            abuf_rd_tail <= mem_t[abuf_rd_addr];
        end else begin
            abuf_rd_data <= ~abuf_rd_data;
            abuf_rd_tail <= ~abuf_rd_tail;
        end
    end

    task automatic chk(input string tag, input logic [DDR_W-1:0] obs, input logic [DDR_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic logic rnd(input int unsigned pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic observe();
        beat_t b;
        if (stall_prev) begin
            chk("valid_hold", ddr_valid, 1'b1);
            chk("stall_data", ddr_data, prev_data);
            chk("stall_last", ddr_last, prev_last);
        end
        if (ddr_valid && ddr_ready) begin
            chk("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_data", ddr_data, b.data);
                chk("beat_last", ddr_last, b.last);
                if (timed_beats) chk("beat_cycle", cyc_n, t0 + 3 + beat_i);
                beat_i++;
                if (b.ent_end) accepted++;
            end
        end
        stall_prev = ddr_valid && !ddr_ready;
        prev_data  = ddr_data;
        prev_last  = ddr_last;
        if (abuf_rd_en) begin
            chk("read_expected", exp_addr.size() != 0, 1'b1);
            if (exp_addr.size() != 0) chk("rd_addr", abuf_rd_addr, exp_addr.pop_front());
            if (timed_reads) chk("rd_cycle", cyc_n, t0 + 1 + rd_i);
            rd_i++;
            chk("outstanding_le2", (rd_i - accepted) <= 2, 1'b1);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
    endtask

    task automatic cyc(input logic rdy, input logic st, input logic r);
        @(negedge clk);
        ddr_ready = rdy;
        start     = st;
        rst       = r;
        #1;
        cyc_n++;
        observe();
    endtask

    // Expected reads and beats derived from the buffer image and the config
    task automatic build(input logic [1:0] ty, input int unsigned num, input int unsigned base);
        beat_t       b;
        logic [TW-1:0] t;
        int unsigned a;
        exp_q.delete();
        exp_addr.delete();
        if (ty != 2'd3) begin
            for (int unsigned e = 0; e <= num; e++) begin
                a = (base + e) % BUF_DEPTH;
                exp_addr.push_back(a);
                if (ty != 2'd1) begin
                    b.data    = mem_d[a];
                    b.ent_end = (ty == 2'd0);
                    b.last    = (ty == 2'd0) && (e == num);
                    exp_q.push_back(b);
                end
                if (ty != 2'd0) begin
                    t = mem_t[a];
                    for (int unsigned k = 0; k < TD_RATE; k++) begin
                        b.data    = t[k*DDR_W +: DDR_W];
                        b.ent_end = (k == TD_RATE - 1);
                        b.last    = (k == TD_RATE - 1) && (e == num);
                        exp_q.push_back(b);
                    end
                end
            end
        end
        beat_i = 0; rd_i = 0; accepted = 0; done_cnt = 0; done_cyc = -1;
        conf_trans_type = ty;
        conf_trans_num  = 8'(num);
        conf_base_addr  = ADDR_W'(base);
    endtask

    task automatic run_xfer(input logic [1:0] ty, input int unsigned num, input int unsigned base,
                            input int unsigned pct, input bit poke);
        int total;
        int budget;
        build(ty, num, base);
        total       = exp_q.size();
        timed_beats = (pct >= 100);
        timed_reads = (pct >= 100) && (ty == 2'd0);
        cyc(rnd(pct), 1'b1, 1'b0);
        t0 = cyc_n;
        chk("done_low_at_start", done, 1'b0);
        budget = 8 * total + 40;
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            if (poke && i == 6) begin
                conf_trans_type = 2'd1;
                conf_trans_num  = 8'd0;
                conf_base_addr  = '0;
                cyc(rnd(pct), 1'b1, 1'b0);
            end else begin
                cyc(rnd(pct), 1'b0, 1'b0);
            end
        end
        chk("done_seen", done_cnt, 1);
        chk("beats_left", exp_q.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
        if (pct >= 100) chk("done_cycle", done_cyc, (ty == 2'd3) ? t0 + 1 : t0 + 3 + total);
    endtask

    initial begin
        for (int a = 0; a < BUF_DEPTH; a++) begin
            for (int w = 0; w < DW / 32; w++) mem_d[a][w*32 +: 32] = $urandom;
            for (int w = 0; w < TW / 32; w++) mem_t[a][w*32 +: 32] = $urandom;
        end
        rst = 1'b1; start = 1'b0; ddr_ready = 1'b0;
        conf_trans_type = '0; conf_trans_num = '0; conf_base_addr = '0;
        stall_prev = 1'b0; timed_beats = 0; timed_reads = 0;
        beat_i = 0; rd_i = 0; accepted = 0; done_cnt = 0; done_cyc = -1; t0 = 0;

        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_valid", ddr_valid, 1'b0);
        chk("rst_last", ddr_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", abuf_rd_en, 1'b0);
        chk("rst_rd_addr", abuf_rd_addr, '0);
        chk("rst_data", ddr_data, '0);

        run_xfer(2'd0, 3, 0, 100, 1'b0);
        run_xfer(2'd2, 1, $urandom_range(BUF_DEPTH - 1), 100, 1'b0);
        run_xfer(2'd0, 7, $urandom_range(BUF_DEPTH - 1), 50, 1'b1);
        run_xfer(2'd0, 3, 510, 50, 1'b0);
        run_xfer(2'd3, 5, 7, 100, 1'b0);
        run_xfer(2'd1, 4, $urandom_range(BUF_DEPTH - 1), 100, 1'b0);
        for (int i = 0; i < 6; i++)
            run_xfer(2'($urandom_range(2)), $urandom_range(20), $urandom_range(BUF_DEPTH - 1),
                     (i % 2 == 1) ? 100 : 60, 1'b0);
        run_xfer(2'd1, 255, 300, 70, 1'b0);

        // Reset while the second beat is on the bus, then a clean single-entry transfer
        build(2'd0, 3, $urandom_range(BUF_DEPTH - 1));
        timed_beats = 1; timed_reads = 1;
        cyc(1'b1, 1'b1, 1'b0);
        t0 = cyc_n;
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        exp_q.delete(); exp_addr.delete();
        timed_beats = 0; timed_reads = 0;
        cyc(1'b1, 1'b0, 1'b0);
        chk("midrst_valid", ddr_valid, 1'b0);
        chk("midrst_last", ddr_last, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_rd_en", abuf_rd_en, 1'b0);
        chk("midrst_rd_addr", abuf_rd_addr, '0);
        chk("midrst_data", ddr_data, '0);
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        chk("midrst_no_done", done_cnt, 0);
        run_xfer(2'd0, 0, $urandom_range(BUF_DEPTH - 1), 100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/abuf2ddr.md
# abuf2ddr

Write-back mover from an accumulation buffer bank to the DDR write stream. It is the reverse path of the DDR-to-buffer loader. On `start` it reads `conf_trans_num+1` consecutive entries from one accumulation-buffer bank and serialises each entry's data and/or tail words into `DDR_W`-bit beats with a valid/ready handshake. It sits between the PE accumulation buffers and the DDR write DMA, and pulses `done` when the last beat has been accepted.

## Interface
Parameters:
- `BUF_DEPTH`, 512: entries per buffer bank.
- `ADDR_W`, `bw(BUF_DEPTH)`: buffer address width.
- `DDR_W`, 512: DDR beat width; must equal `BATCH*DATA_W`.
- `BATCH`, `DATA_W`, `TAIL_W`: taken from GLOBAL_PARAM. `BATCH*TAIL_W` must be a multiple of `DDR_W`, and `TD_RATE = BATCH*TAIL_W/DDR_W` (2 for 32/16/32).

Ports:
- `clk` in 1: sole clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: one-cycle pulse; sampled only in IDLE.
- `done` out 1: one-cycle pulse after the final beat handshake.
- `conf_trans_type` in 2: 0 = data only, 1 = tail only, 2 = data+tail, 3 = reserved.
- `conf_trans_num` in 8: number of entries minus 1 (1..256 entries).
- `conf_base_addr` in `ADDR_W`: first buffer entry.
- `abuf_rd_en` out 1: buffer read strobe.
- `abuf_rd_addr` out `ADDR_W`: buffer read address.
- `abuf_rd_data` in `BATCH*DATA_W`: valid exactly 1 cycle after `abuf_rd_en`.
- `abuf_rd_tail` in `BATCH*TAIL_W`: valid exactly 1 cycle after `abuf_rd_en`.
- `ddr_data` out `DDR_W`: beat payload.
- `ddr_valid` out 1: beat valid.
- `ddr_last` out 1: final beat of the transfer.
- `ddr_ready` in 1: DDR side accepts the beat.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start` when `conf_trans_type != 3`. The config is latched that cycle.
- IDLE → DONE on `start` when `conf_trans_type == 3`. No reads and no beats occur.
- RUN → DONE on the handshake of the beat flagged `ddr_last`.
- DONE → IDLE unconditionally. `done` is high only in DONE.
- `start` outside IDLE is ignored, and the latched config does not change.
- Read issue: the read address starts at `conf_base_addr` and increments per read, wrapping from `BUF_DEPTH-1` to 0.
  - `abuf_rd_en` is asserted when reads remain and (held entries + reads in flight) < 2.
  - The block holds a 2-entry holding buffer of {data, tail}. Reads never overrun it.
- Beats per entry:
  - Type 0: 1 beat, `ddr_data = data`.
  - Type 1: `TD_RATE` beats; beat k = `tail[k*DDR_W +: DDR_W]`, k ascending.
  - Type 2: the data beat, then the `TD_RATE` tail beats.
- Lane mapping: data lane i is at bits `[i*DATA_W +: DATA_W]`, unchanged from the buffer.
- A held entry is freed on the handshake of its final beat.
- `ddr_last` is high on the final beat of the final entry only.

## Timing
- Reset values: `done`, `ddr_valid`, `ddr_last`, `abuf_rd_en` = 0; `abuf_rd_addr`, `ddr_data` = 0; FSM = IDLE; holding buffer empty; counters = 0.
- Latency, with `start` in cycle T:
  - First `abuf_rd_en` in T+1.
  - Data captured at the end of T+2.
  - First `ddr_valid` in T+3.
- Throughput: with `ddr_ready` held high, type 0 sustains one beat per cycle (N entries finish by T+2+N). Types 1 and 2 sustain one beat per cycle as well.
- Handshake rules:
  - A beat transfers when `ddr_valid && ddr_ready`.
  - While `ddr_valid && !ddr_ready`, `ddr_data`, `ddr_valid` and `ddr_last` hold stable.
  - `ddr_valid` never drops without a handshake.
- `done` rises the cycle after the last handshake and lasts exactly 1 cycle. A new `start` is accepted the cycle after `done`.
- Reset mid-transfer: the next cycle is IDLE with outputs at reset values. No `done`, no further reads.
- `conf_trans_num = 255` moves 256 entries. The 9-bit internal entry counter must not overflow.

## Test plan
- Type 0, base 0, num 3, `ddr_ready` = 1:
  - Reads of addresses 0..3 in T+1..T+4.
  - 4 beats in T+3..T+6 equal to buffer data.
  - `ddr_last` on the 4th beat; `done` at T+7.
- Type 2, num 1, `TAIL_W` = 32, `TD_RATE` = 2:
  - 6 beats in order data0, tail0 low, tail0 high, data1, tail1 low, tail1 high.
  - `ddr_last` only on the 6th beat.
- Backpressure: type 0, num 7, `ddr_ready` random at 50%:
  - Beats stay in order with no loss or duplication.
  - Data stays stable while stalled.
  - At most 2 reads are outstanding beyond accepted entries.
- Wrap: base 510, num 3, `BUF_DEPTH` 512 → read addresses 510, 511, 0, 1.
- Reserved type 3 → no `abuf_rd_en` and no `ddr_valid`; `done` pulses at T+1.
- `rst` at the 2nd beat of a 4-entry transfer → outputs return to 0 the next cycle and no `done` follows. A subsequent `start` with num 0 runs cleanly: 1 beat, then `done`.
